// File: rtl/unidade_alu_multiciclo.sv
// Sequential ALU with valid/ready request and response sides. Single-cycle
// add/sub/and/or/xor, and an iterative shift-add unsigned multiply.
module unidade_alu_multiciclo #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valido,
  output logic               req_pronto,
  input  logic [LARGURA-1:0] entradaA,
  input  logic [LARGURA-1:0] entradaB,
  input  logic [3:0]         operacao,
  output logic               resp_valido,
  input  logic               resp_pronto,
  output logic [LARGURA-1:0] resultado,
  output logic               carry_out,
  output logic               zero_flag,
  output logic               erro_op,
  output logic [1:0]         o_estado
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both 1; ready is a function of state only, and valid, once raised by the
  // DUT, holds with stable data until the transfer.
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CALCULA  = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  localparam int         CW       = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [CW-1:0] CONT_MAX = CW'(LARGURA - 1);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  estado_t                r_estado;
  estado_t                w_prox;
  logic [2*LARGURA-1:0]   r_mcand;
  logic [2*LARGURA-1:0]   r_acc;
  logic [LARGURA-1:0]     r_mult;
  logic [CW-1:0]          r_cont;
  logic [LARGURA-1:0]     r_resultado;
  logic                   r_carry;
  logic                   r_zero;
  logic                   r_erro;

  logic                   w_aceita;
  logic [LARGURA:0]       w_soma;
  logic [LARGURA:0]       w_dif;
  logic [LARGURA-1:0]     w_res;
  logic                   w_carry;
  logic                   w_erro;
  logic [2*LARGURA-1:0]   w_acc_prox;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= OCIOSO;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox      = r_estado;
    req_pronto  = 1'b0;
    resp_valido = 1'b0;
    case (r_estado)
      OCIOSO: begin
        req_pronto = 1'b1;
        if (req_valido) w_prox = (operacao == OP_MUL) ? CALCULA : RESPOSTA;
      end
      CALCULA: begin
        if (r_cont == CONT_MAX) w_prox = RESPOSTA;
      end
      RESPOSTA: begin
        resp_valido = 1'b1;
        if (resp_pronto) w_prox = OCIOSO;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  assign w_aceita = req_valido & req_pronto;

  // Bit LARGURA of the widened difference is the unsigned borrow.
  assign w_soma = {1'b0, entradaA} + {1'b0, entradaB};
  assign w_dif  = {1'b0, entradaA} - {1'b0, entradaB};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_erro  = 1'b0;
    case (operacao)
      OP_ADD: begin w_res = w_soma[LARGURA-1:0]; w_carry = w_soma[LARGURA]; end
      OP_SUB: begin w_res = w_dif[LARGURA-1:0];  w_carry = w_dif[LARGURA];  end
      OP_AND: w_res = entradaA & entradaB;
      OP_OR:  w_res = entradaA | entradaB;
      OP_XOR: w_res = entradaA ^ entradaB;
      OP_MUL: w_erro = 1'b0;
      default: w_erro = 1'b1;
    endcase
  end

  assign w_acc_prox = r_mult[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand     <= '0;
      r_acc       <= '0;
      r_mult      <= '0;
      r_cont      <= '0;
      r_resultado <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_erro      <= 1'b0;
    end else if (w_aceita) begin
      if (operacao == OP_MUL) begin
        r_mcand <= {{LARGURA{1'b0}}, entradaA};
        r_mult  <= entradaB;
        r_acc   <= '0;
        r_cont  <= '0;
      end else begin
        r_resultado <= w_res;
        r_carry     <= w_carry;
        r_zero      <= (w_res == '0);
        r_erro      <= w_erro;
      end
    end else if (r_estado == CALCULA) begin
      r_acc   <= w_acc_prox;
      r_mcand <= r_mcand << 1;
      r_mult  <= r_mult >> 1;
      r_cont  <= r_cont + 1'b1;
      // Result registers are only written on the last iteration, i.e. on entry to RESPOSTA.
      if (r_cont == CONT_MAX) begin
        r_resultado <= w_acc_prox[LARGURA-1:0];
        r_carry     <= |w_acc_prox[2*LARGURA-1:LARGURA];
        r_zero      <= (w_acc_prox[LARGURA-1:0] == '0);
        r_erro      <= 1'b0;
      end
    end
  end

  assign resultado = r_resultado;
  assign carry_out = r_carry;
  assign zero_flag = r_zero;
  assign erro_op   = r_erro;
  assign o_estado  = r_estado;

endmodule

// File: tb/tb_unidade_alu_multiciclo.sv
// Directed-vector bench for unidade_alu_multiciclo: latency, flags,
// backpressure, input isolation during multiply, and mid-operation reset.
module tb_unidade_alu_multiciclo;

  logic       clk;
  logic       rst_n;
  logic       req_valido;
  logic       req_pronto;
  logic [7:0] entradaA;
  logic [7:0] entradaB;
  logic [3:0] operacao;
  logic       resp_valido;
  logic       resp_pronto;
  logic [7:0] resultado;
  logic       carry_out;
  logic       zero_flag;
  logic       erro_op;
  logic [1:0] o_estado;

  int n_vec;
  int n_err;

  unidade_alu_multiciclo #(.LARGURA(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valido  (req_valido),
    .req_pronto  (req_pronto),
    .entradaA    (entradaA),
    .entradaB    (entradaB),
    .operacao    (operacao),
    .resp_valido (resp_valido),
    .resp_pronto (resp_pronto),
    .resultado   (resultado),
    .carry_out   (carry_out),
    .zero_flag   (zero_flag),
    .erro_op     (erro_op),
    .o_estado    (o_estado)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: waits for req_pronto, presents a request for one edge
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int guard;
    guard = 0;
    while (!req_pronto && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check_eq("req_pronto_timeout", 0, 1);
    entradaA   = a;
    entradaB   = b;
    operacao   = op;
    req_valido = 1'b1;
    @(posedge clk); #1;
    req_valido = 1'b0;
  endtask

  // runs one transaction; toggle scrambles inputs during the wait,
  // hold keeps resp_pronto low for that many cycles before consuming
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic [7:0] exp_res, input logic exp_c,
                       input logic exp_z, input logic exp_e, input int exp_lat,
                       input bit toggle, input int hold);
    int lat;
    logic [10:0] snap;
    accept(a, b, op);
    lat = 0;
    while (!resp_valido && lat < 50) begin
      if (toggle) begin
        entradaA   = 8'($urandom_range(0, 255));
        entradaB   = 8'($urandom_range(0, 255));
        operacao   = 4'($urandom_range(0, 15));
        req_valido = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    req_valido = 1'b0;
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, resultado, exp_res);
    check_eq({tag, "_flags"}, {carry_out, zero_flag, erro_op}, {exp_c, exp_z, exp_e});
    snap = {resultado, carry_out, zero_flag, erro_op};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_out"}, {resp_valido, resultado, carry_out, zero_flag, erro_op},
               {1'b1, snap});
      check_eq({tag, "_hold_rdy"}, req_pronto, 0);
    end
    resp_pronto = 1'b1;
    @(posedge clk); #1;
    resp_pronto = 1'b0;
    check_eq({tag, "_done"}, {req_pronto, resp_valido}, 2'b10);
  endtask

  initial begin
    bit seen_resp;
    n_vec       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    req_valido  = 1'b0;
    resp_pronto = 1'b0;
    entradaA    = '0;
    entradaB    = '0;
    operacao    = '0;
    #1;
    check_eq("reset_hs", {req_pronto, resp_valido}, 2'b10);
    check_eq("reset_out", {resultado, carry_out, zero_flag, erro_op}, 11'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add",   8'd15,  8'd10, 4'b0000, 8'd25,  1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    do_op("sub",   8'd25,  8'd30, 4'b0001, 8'hFB,  1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    do_op("addov", 8'd200, 8'd56, 4'b0000, 8'd0,   1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    do_op("and",   8'hAA,  8'hCC, 4'b0010, 8'h88,  1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    do_op("or",    8'hAA,  8'hCC, 4'b0011, 8'hEE,  1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    do_op("xor",   8'hAA,  8'hCC, 4'b0100, 8'h66,  1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    do_op("badop", 8'hAA,  8'hCC, 4'b0111, 8'd0,   1'b0, 1'b1, 1'b1, 0, 1'b0, 0);
    do_op("mul1",  8'd100, 8'd3,  4'b1000, 8'd44,  1'b1, 1'b0, 1'b0, 8, 1'b0, 0);
    do_op("mul2",  8'd12,  8'd10, 4'b1000, 8'd120, 1'b0, 1'b0, 1'b0, 8, 1'b1, 5);
    do_op("mul0",  8'd255, 8'd0,  4'b1000, 8'd0,   1'b0, 1'b1, 1'b0, 8, 1'b0, 0);
    do_op("bp_sc", 8'd7,   8'd9,  4'b0001, 8'hFE,  1'b1, 1'b0, 1'b0, 0, 1'b0, 3);

    // reset in the middle of 100x3
    accept(8'd100, 8'd3, 4'b1000);
    repeat (4) @(posedge clk);
    #2;
    check_eq("pre_rst_busy", req_pronto, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_hs", {req_pronto, resp_valido}, 2'b10);
    check_eq("midrst_out", {resultado, carry_out, zero_flag, erro_op}, 11'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    seen_resp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (resp_valido) seen_resp = 1'b1;
    end
    check_eq("postrst_no_resp", seen_resp, 0);
    do_op("add2",  8'd15,  8'd10, 4'b0000, 8'd25,  1'b0, 1'b0, 1'b0, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
